ecc_harq_tx: RTL and testbench
==============================

ECC_HARQ_TX -- requirements
Module: ecc_harq_tx

Interface
REQ-001 Parameter MAX_RETX, default 3, maximum retransmissions per flit after the first send (legal 0..15).
REQ-002 Parameter ACK_TIMEOUT, default 16, cycles spent in WAIT_ACK without ack/nack before an implicit nack (legal 2..255).
REQ-003 i_aclk  input  1  single clock; all state on rising edge.
REQ-004 i_aresetn  input  1  reset, asynchronous and active-low.
REQ-005 i_enable_ecc  input  1  1 = insert check byte; 0 = check byte forced 8'h00.
REQ-006 i_wvalid  input  1  upstream offers a 32-bit word.
REQ-007 i_wdata  input  32  upstream data word.
REQ-008 o_wready  output  1  block can accept a word this cycle.
REQ-009 o_wvalid  output  1  flit on o_wdata is valid toward the link.
REQ-010 o_wdata  output  40  flit: [39:32] check byte, [31:0] data.
REQ-011 i_ack  input  1  receiver accepted the outstanding flit.
REQ-012 i_nack  input  1  receiver reported an uncorrectable error on the outstanding flit.
REQ-013 o_retx_cnt  output  4  retransmissions issued for the current flit.
REQ-014 o_retx_fail  output  1  one-cycle pulse: flit dropped after MAX_RETX retransmissions.

Function
REQ-015 Encoding: every bit of the check byte SHALL equal the XOR-reduction of data[31:0] when ECC is enabled (link receiver's check function), so even-parity data gives 8'h00 and odd-parity data gives 8'hFF.
REQ-016 The complete 40-bit flit, including the i_enable_ecc value, SHALL be computed and latched at acceptance; retransmissions SHALL be bit-identical.
REQ-017 FSM states IDLE, SEND, WAIT_ACK, FAIL; only one flit outstanding at any time.
REQ-018 IDLE: o_wready=1; i_wvalid=1 -> latch flit, clear o_retx_cnt, go SEND; otherwise stay.
REQ-019 o_wready SHALL be 0 in SEND, WAIT_ACK and FAIL; i_wvalid is ignored there.
REQ-020 SEND: o_wvalid=1 for exactly one cycle with the latched flit; next state WAIT_ACK with the timeout counter at 0.
REQ-021 Latency: word accepted on edge N -> o_wvalid high in the cycle after edge N (one cycle); o_wvalid and o_wdata SHALL be register outputs.
REQ-022 WAIT_ACK: timeout counter increments each cycle; i_ack -> IDLE with o_retx_cnt cleared to 0.
REQ-023 WAIT_ACK: i_nack, or counter reaching ACK_TIMEOUT-1 without ack, is a retry event: if o_retx_cnt < MAX_RETX -> increment o_retx_cnt and go SEND; else go FAIL.
REQ-024 i_ack and i_nack asserted together: ack wins.
REQ-025 i_ack or i_nack outside WAIT_ACK (including in SEND) SHALL be ignored.
REQ-026 FAIL: o_retx_fail=1 for exactly one cycle, drop the flit, clear o_retx_cnt, next state IDLE.
REQ-027 MAX_RETX=0: the first retry event goes directly to FAIL.
REQ-028 o_wdata SHALL hold its last value while o_wvalid=0.
REQ-029 Spacing between consecutive sends of one flit on timeout SHALL be ACK_TIMEOUT+1 cycles.

Reset
REQ-030 Asserting i_aresetn low SHALL immediately force state IDLE, o_wvalid=0, o_wdata=40'h0, o_retx_cnt=0, o_retx_fail=0, and timeout counter=0; o_wready=1 follows from IDLE.
REQ-031 Reset mid-operation (SEND/WAIT_ACK/FAIL) SHALL discard the outstanding flit without an o_retx_fail pulse.
REQ-032 On the first edge after deassertion, the block SHALL accept a word.

Verification
REQ-033 ECC on, i_wdata=32'h0000_0001, i_ack 3 cycles after send -> one o_wvalid pulse, o_wdata=40'hFF_0000_0001, o_wready=1 the cycle after the ack.
REQ-034 ECC on, i_wdata=32'h0000_0003 -> o_wdata=40'h00_0000_0003; ECC off, i_wdata=32'h0000_0001 -> o_wdata=40'h00_0000_0001.
REQ-035 Two nacks, then ack -> three identical o_wvalid pulses; o_retx_cnt steps 0->1->2, then returns to 0 on ack.
REQ-036 Defaults, no ack/nack -> four sends 17 cycles apart, o_retx_cnt reaches 3, one o_retx_fail pulse, then o_wready=1.
REQ-037 i_ack and i_nack high together in WAIT_ACK -> no retransmission, return to IDLE; ack during SEND -> ignored.
REQ-038 i_aresetn pulsed low during WAIT_ACK -> all outputs at reset values asynchronously, no o_retx_fail, new word accepted on the first edge after release.

Source files
------------

// File: rtl/ecc_harq_tx_if.sv
// Upstream word handshake plus link-side flit/ack signals for ecc_harq_tx.
// slave = the transmitter's view, master = the driver/link side.
interface ecc_harq_tx_if;
    logic        i_wvalid;
    logic [31:0] i_wdata;
    logic        o_wready;
    logic        o_wvalid;
    logic [39:0] o_wdata;
    logic        i_ack;
    logic        i_nack;
    logic [3:0]  o_retx_cnt;
    logic        o_retx_fail;

    modport slave (
        input  i_wvalid, i_wdata, i_ack, i_nack,
        output o_wready, o_wvalid, o_wdata, o_retx_cnt, o_retx_fail
    );

    modport master (
        output i_wvalid, i_wdata, i_ack, i_nack,
        input  o_wready, o_wvalid, o_wdata, o_retx_cnt, o_retx_fail
    );
endinterface

// File: rtl/ecc_harq_tx.sv
// Single-outstanding-flit HARQ transmitter: appends a parity check byte,
// resends on nack or ack timeout, and drops the flit after MAX_RETX retries.
module ecc_harq_tx #(
    parameter int unsigned MAX_RETX    = 3,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic              i_aclk,
    input  logic              i_aresetn,
    input  logic              i_enable_ecc,
    ecc_harq_tx_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACK,
        S_FAIL
    } state_t;

    localparam logic [7:0] TMO_LAST  = 8'(ACK_TIMEOUT - 1);
    localparam logic [3:0] RETX_LIMIT = 4'(MAX_RETX);

    state_t      state_q;
    logic        wvalid_q;
    logic [39:0] wdata_q;
    logic [3:0]  retx_q;
    logic        fail_q;
    logic [7:0]  tmo_q;

    logic [39:0] flit_d;
    logic        retry_d;

    // Every check bit carries the word parity, matching the receiver's check.
    always_comb begin
        flit_d = {(i_enable_ecc ? {8{^bus.i_wdata}} : 8'h00), bus.i_wdata};
        retry_d = bus.i_nack || (tmo_q == TMO_LAST);
    end

    // wdata_q doubles as the retransmit buffer: it only changes on acceptance.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q  <= S_IDLE;
            wvalid_q <= 1'b0;
            wdata_q  <= '0;
            retx_q   <= '0;
            fail_q   <= 1'b0;
            tmo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    fail_q <= 1'b0;
                    if (bus.i_wvalid) begin
                        wdata_q  <= flit_d;
                        wvalid_q <= 1'b1;
                        retx_q   <= '0;
                        state_q  <= S_SEND;
                    end
                end
                S_SEND: begin
                    wvalid_q <= 1'b0;
                    tmo_q    <= '0;
                    state_q  <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    tmo_q <= tmo_q + 8'd1;
                    if (bus.i_ack) begin
                        retx_q  <= '0;
                        state_q <= S_IDLE;
                    end else if (retry_d) begin
                        if (retx_q < RETX_LIMIT) begin
                            retx_q   <= retx_q + 4'd1;
                            wvalid_q <= 1'b1;
                            state_q  <= S_SEND;
                        end else begin
                            fail_q  <= 1'b1;
                            state_q <= S_FAIL;
                        end
                    end
                end
                S_FAIL: begin
                    fail_q  <= 1'b0;
                    retx_q  <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_wready    = (state_q == S_IDLE);
    assign bus.o_wvalid    = wvalid_q;
    assign bus.o_wdata     = wdata_q;
    assign bus.o_retx_cnt  = retx_q;
    assign bus.o_retx_fail = fail_q;

endmodule

// File: tb/tb_ecc_harq_tx.sv
// Directed self-checking bench for ecc_harq_tx (default parameters plus a
// MAX_RETX=0 instance).
module tb_ecc_harq_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic en0 = 1'b1;
    int checks = 0;
    int failures = 0;

    ecc_harq_tx_if bus ();
    ecc_harq_tx_if bus0 ();

    ecc_harq_tx #(.MAX_RETX(3), .ACK_TIMEOUT(16)) dut (
        .i_aclk(clk), .i_aresetn(rst_n), .i_enable_ecc(en), .bus(bus)
    );

    ecc_harq_tx #(.MAX_RETX(0), .ACK_TIMEOUT(2)) dut0 (
        .i_aclk(clk), .i_aresetn(rst_n), .i_enable_ecc(en0), .bus(bus0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one word for one edge; afterwards the DUT is in its SEND cycle.
    task automatic offer(input logic [31:0] d);
        bus.i_wvalid = 1'b1;
        bus.i_wdata  = d;
        tick();
        bus.i_wvalid = 1'b0;
    endtask

    int send_t[4];
    int nsend;
    int nfail;
    int fail_t;
    logic [3:0] max_retx;

    initial begin
        bus.i_wvalid = 1'b0; bus.i_wdata = '0; bus.i_ack = 1'b0; bus.i_nack = 1'b0;
        bus0.i_wvalid = 1'b0; bus0.i_wdata = '0; bus0.i_ack = 1'b0; bus0.i_nack = 1'b0;
        #1;
        chk("rst_wready", 64'(bus.o_wready), 64'd1);
        chk("rst_wvalid", 64'(bus.o_wvalid), 64'd0);
        chk("rst_wdata",  64'(bus.o_wdata), 64'd0);
        chk("rst_retx",   64'(bus.o_retx_cnt), 64'd0);
        chk("rst_fail",   64'(bus.o_retx_fail), 64'd0);
        tick(); tick();
        rst_n = 1'b1;

        // Odd-parity word with ECC on, ack three cycles after the send.
        en = 1'b1;
        offer(32'h0000_0001);
        chk("t1_wvalid", 64'(bus.o_wvalid), 64'd1);
        chk("t1_wdata",  64'(bus.o_wdata), 64'hFF_0000_0001);
        chk("t1_wready", 64'(bus.o_wready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_wait_wvalid", 64'(bus.o_wvalid), 64'd0);
            chk("t1_hold_wdata",  64'(bus.o_wdata), 64'hFF_0000_0001);
        end
        bus.i_ack = 1'b1;
        tick();
        bus.i_ack = 1'b0;
        chk("t1_ready_after_ack", 64'(bus.o_wready), 64'd1);
        chk("t1_retx_after_ack",  64'(bus.o_retx_cnt), 64'd0);

        // Even-parity word with ECC on, then ECC off.
        offer(32'h0000_0003);
        chk("t2_even_wdata", 64'(bus.o_wdata), 64'h00_0000_0003);
        tick(); bus.i_ack = 1'b1; tick(); bus.i_ack = 1'b0;
        en = 1'b0;
        offer(32'h0000_0001);
        chk("t2_noecc_wdata", 64'(bus.o_wdata), 64'h00_0000_0001);
        tick(); bus.i_ack = 1'b1; tick(); bus.i_ack = 1'b0;
        chk("t2_ready", 64'(bus.o_wready), 64'd1);

        // Two nacks then ack; a competing upstream word must be ignored.
        en = 1'b1;
        offer(32'h8000_0000);
        chk("t3_send0_wdata", 64'(bus.o_wdata), 64'hFF_8000_0000);
        chk("t3_send0_retx",  64'(bus.o_retx_cnt), 64'd0);
        tick();
        bus.i_wvalid = 1'b1; bus.i_wdata = 32'hDEAD_BEEF;
        bus.i_nack = 1'b1; tick(); bus.i_nack = 1'b0;
        chk("t3_send1_wvalid", 64'(bus.o_wvalid), 64'd1);
        chk("t3_send1_wdata",  64'(bus.o_wdata), 64'hFF_8000_0000);
        chk("t3_send1_retx",   64'(bus.o_retx_cnt), 64'd1);
        tick();
        bus.i_nack = 1'b1; tick(); bus.i_nack = 1'b0;
        bus.i_wvalid = 1'b0;
        chk("t3_send2_wvalid", 64'(bus.o_wvalid), 64'd1);
        chk("t3_send2_wdata",  64'(bus.o_wdata), 64'hFF_8000_0000);
        chk("t3_send2_retx",   64'(bus.o_retx_cnt), 64'd2);
        tick();
        bus.i_ack = 1'b1; tick(); bus.i_ack = 1'b0;
        chk("t3_ack_retx",  64'(bus.o_retx_cnt), 64'd0);
        chk("t3_ack_ready", 64'(bus.o_wready), 64'd1);

        // Ack during SEND is ignored; ack+nack together means ack.
        bus.i_wvalid = 1'b1; bus.i_wdata = 32'h0000_0007;
        bus.i_ack = 1'b1;
        tick();
        bus.i_wvalid = 1'b0;
        chk("t4_in_send", 64'(bus.o_wvalid), 64'd1);
        tick();
        bus.i_ack = 1'b0;
        chk("t4_send_ack_ignored", 64'(bus.o_wready), 64'd0);
        bus.i_ack = 1'b1; bus.i_nack = 1'b1;
        tick();
        bus.i_ack = 1'b0; bus.i_nack = 1'b0;
        chk("t4_both_ready",  64'(bus.o_wready), 64'd1);
        chk("t4_both_wvalid", 64'(bus.o_wvalid), 64'd0);
        chk("t4_both_retx",   64'(bus.o_retx_cnt), 64'd0);
        tick();
        chk("t4_no_retx_send", 64'(bus.o_wvalid), 64'd0);

        // Silent link: sends 17 cycles apart, then one fail pulse.
        offer(32'h1234_5678);
        chk("t5_wdata", 64'(bus.o_wdata), 64'hFF_1234_5678);
        nsend = 0; nfail = 0; fail_t = -1; max_retx = '0;
        for (int c = 0; c < 76; c++) begin
            if (bus.o_wvalid) begin
                if (nsend < 4) send_t[nsend] = c;
                nsend++;
            end
            if (bus.o_retx_fail) begin
                nfail++;
                fail_t = c;
            end
            if (bus.o_retx_cnt > max_retx) max_retx = bus.o_retx_cnt;
            if (c == 69) chk("t5_ready_after_fail", 64'(bus.o_wready), 64'd1);
            if (c == 69) chk("t5_retx_cleared", 64'(bus.o_retx_cnt), 64'd0);
            tick();
        end
        chk("t5_nsend", 64'(nsend), 64'd4);
        for (int k = 1; k < 4; k++)
            chk("t5_spacing", 64'(send_t[k] - send_t[k-1]), 64'd17);
        chk("t5_max_retx", 64'(max_retx), 64'd3);
        chk("t5_nfail",    64'(nfail), 64'd1);
        chk("t5_fail_t",   64'(fail_t), 64'd68);

        // MAX_RETX=0: first nack goes straight to FAIL.
        bus0.i_wvalid = 1'b1; bus0.i_wdata = 32'h0000_0001;
        tick();
        bus0.i_wvalid = 1'b0;
        chk("t6_send", 64'(bus0.o_wvalid), 64'd1);
        tick();
        bus0.i_nack = 1'b1; tick(); bus0.i_nack = 1'b0;
        chk("t6_fail_pulse", 64'(bus0.o_retx_fail), 64'd1);
        chk("t6_no_resend",  64'(bus0.o_wvalid), 64'd0);
        tick();
        chk("t6_fail_end",  64'(bus0.o_retx_fail), 64'd0);
        chk("t6_ready",     64'(bus0.o_wready), 64'd1);

        // Asynchronous reset while waiting for ack after one retry.
        offer(32'h0000_00FF);
        tick();
        bus.i_nack = 1'b1; tick(); bus.i_nack = 1'b0;
        tick(); tick();
        chk("t7_pre_retx", 64'(bus.o_retx_cnt), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_wvalid", 64'(bus.o_wvalid), 64'd0);
        chk("t7_rst_wdata",  64'(bus.o_wdata), 64'd0);
        chk("t7_rst_retx",   64'(bus.o_retx_cnt), 64'd0);
        chk("t7_rst_fail",   64'(bus.o_retx_fail), 64'd0);
        chk("t7_rst_ready",  64'(bus.o_wready), 64'd1);
        tick();
        chk("t7_rst_no_fail", 64'(bus.o_retx_fail), 64'd0);
        rst_n = 1'b1;
        en = 1'b1;
        offer(32'h0000_0003);
        chk("t7_accept_wvalid", 64'(bus.o_wvalid), 64'd1);
        chk("t7_accept_wdata",  64'(bus.o_wdata), 64'h00_0000_0003);
        tick();
        chk("t7_no_fail_after", 64'(bus.o_retx_fail), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
